killer_sequencer: RTL and testbench
===================================

Name: killer_sequencer

Overview:
- Sequences all writes into the killer-move evaluator and shares its single ply bus (killer_ply) between two requesters: the search engine's evaluation path and killer-table updates/clears.
- Converts valid/ready update and clear requests into the evaluator's edge-triggered killer_update/killer_clear pulses.
- Holds killer_ply stable long enough for the evaluator's two-stage ply pipeline to settle before each pulse.
- Sits between the search controller and the evaluation tree.

Parameters:
- MAX_DEPTH_LOG2, 0, ply index width; must be set by the instantiating module.
- SETUP_CYCLES, 3, cycles killer_ply/killer_board are held before the killer_update rising edge; minimum legal value 3.
- GAP_CYCLES, 1, low cycles after any pulse before the next pulse; minimum 1.
- FIFO_DEPTH_LOG2, 1, update request buffer depth log2 (default 2 entries).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- upd_valid  in  1  update request valid
- upd_ready  out  1  update buffer not full
- upd_ply  in  MAX_DEPTH_LOG2  ply of cutoff move
- upd_board  in  `BOARD_WIDTH  board after killer move
- clr_valid  in  1  clear-all request
- clr_ready  out  1  clear accepted this cycle
- eval_req  in  1  evaluation wants the ply bus; held for the whole evaluation
- eval_ply  in  MAX_DEPTH_LOG2  ply of board being evaluated
- eval_grant  out  1  ply bus owned by eval
- killer_ply  out  MAX_DEPTH_LOG2  to evaluator
- killer_board  out  `BOARD_WIDTH  to evaluator
- killer_update  out  1  single-cycle pulse
- killer_clear  out  1  single-cycle pulse
- busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- All outputs are registered. Reset (async assert, sync release) forces:
  - killer_update, killer_clear, eval_grant, clr_ready = 0
  - killer_ply, killer_board = 0
  - FIFO empty, so upd_ready = 1
  - FSM in IDLE
- Update FIFO:
  - Write on upd_valid && upd_ready.
  - upd_ready = !full.
  - Pointers wrap modulo depth.
  - Simultaneous push and pop when full is not allowed; upd_ready is low when full.
- FSM states: IDLE, CLR_PULSE, GAP, UPD_SETUP, UPD_PULSE, EVAL.
- IDLE priority, evaluated each cycle:
  1. clr_valid -> CLR_PULSE. clr_ready pulses for 1 cycle and the FIFO is flushed; a push in the same cycle is also discarded.
  2. FIFO non-empty and (eval_req == 0 or last_was_eval) -> pop; latch ply/board onto killer_ply/killer_board; go to UPD_SETUP.
  3. eval_req -> EVAL with eval_grant = 1.
  - last_was_eval is set on EVAL exit and cleared on pop. This gives fairness: one update may run between back-to-back evaluations.
- CLR_PULSE: killer_clear = 1 for exactly 1 cycle -> GAP.
- UPD_SETUP: counter runs SETUP_CYCLES cycles with ply/board held -> UPD_PULSE.
- UPD_PULSE: killer_update = 1 for 1 cycle, ply/board still held -> GAP.
- GAP: GAP_CYCLES cycles, outputs held -> IDLE.
- EVAL:
  - killer_ply follows eval_ply, registered one cycle.
  - When eval_req drops: eval_grant = 0 next cycle -> IDLE.
  - clr_valid and queued updates wait.
- Timing: with FSM in IDLE, FIFO empty, eval idle, and a push at edge E:
  - killer_ply = upd_ply from edge E+2.
  - killer_update is high from edge E+2+SETUP_CYCLES for one cycle.
- A clear arriving during UPD_SETUP waits; the in-flight update completes first.
- killer_update and killer_clear are never high together and never high in consecutive cycles.
- Reset mid-pulse: the pulse drops immediately (async).

Decomposition:
- `BOARD_WIDTH and `MAX_DEPTH come from numbat.vh.
- FSM state encoding localparams stay local to the module.
- The request FIFO is one sub-module, killer_req_fifo (parameterised width/depth, registered full/empty).

Test Plan:
- Reset then idle, upd_valid for one cycle with ply=5, board=B1 -> killer_ply=5 and killer_board=B1 from E+2; killer_update high exactly at E+5; busy low after the GAP cycle.
- Three back-to-back pushes with ply 1, 2, 3 -> upd_ready low after two accepted; third accepted after the first pop; three update pulses in order 1, 2, 3, each separated by ≥1 low cycle.
- clr_valid asserted with two updates queued -> clr_ready and killer_clear pulse once; FIFO flushed; no killer_update follows.
- eval_req held 10 cycles with eval_ply=7 while update ply=2 is queued -> eval_grant held; killer_ply=7; no update until eval_grant falls; then update pulse with ply=2 before a re-asserted eval_req is granted.
- clr_valid raised during UPD_SETUP -> killer_update completes first; killer_clear pulses only after GAP.
- Assert reset during UPD_PULSE -> killer_update=0 immediately; after release upd_ready=1, busy=0, killer_ply=0.

Source files
------------

// File: rtl/killer_sequencer_pkg.sv
// Shared widths and helpers for the killer-move sequencer.
package killer_sequencer_pkg;

  localparam int BOARD_WIDTH        = 64;
  localparam int MAX_DEPTH          = 64;
  localparam int DEF_MAX_DEPTH_LOG2 = $clog2(MAX_DEPTH);

  // Width of the shared setup/gap down-counter; it must hold the larger load value.
  function automatic int cnt_width(input int setup_cycles, input int gap_cycles);
    int top;
    top = (setup_cycles > gap_cycles) ? setup_cycles : gap_cycles;
    return (top < 2) ? 1 : $clog2(top + 1);
  endfunction

endpackage

// File: rtl/killer_req_fifo.sv
// Update request buffer: registered full/empty flags and a registered read port,
// so popped data appears on rd_data the cycle after pop.
module killer_req_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_inc;
  logic [DEPTH_LOG2-1:0] rd_ptr_inc;

  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign rd_ptr_inc = rd_ptr_q + PTR_ONE;

  // Storage array; a push during a flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers, occupancy flags and the registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      rd_data  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_inc;
      if (pop) begin
        rd_ptr_q <= rd_ptr_inc;
        rd_data  <= mem_q[rd_ptr_q];
      end
      if (push && !pop) begin
        empty <= 1'b0;
        full  <= (wr_ptr_inc == rd_ptr_q);
      end else if (pop && !push) begin
        full  <= 1'b0;
        empty <= (rd_ptr_inc == wr_ptr_q);
      end
    end
  end

endmodule

// File: rtl/killer_sequencer.sv
// Arbitrates the evaluator's ply bus between evaluation and killer-table writes,
// turning update/clear requests into spaced single-cycle pulses.
//
// state       | meaning
// S_IDLE      | pick clear, queued update or evaluation (in that priority)
// S_CLR_PULSE | killer_clear high for one cycle
// S_GAP       | mandatory low cycles after any pulse
// S_UPD_SETUP | ply/board driven and settling before the update edge
// S_UPD_PULSE | killer_update high for one cycle
// S_EVAL      | bus granted to evaluation, killer_ply tracks eval_ply
module killer_sequencer
  import killer_sequencer_pkg::*;
#(
  parameter int MAX_DEPTH_LOG2  = DEF_MAX_DEPTH_LOG2,
  parameter int SETUP_CYCLES    = 3,
  parameter int GAP_CYCLES      = 1,
  parameter int FIFO_DEPTH_LOG2 = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [MAX_DEPTH_LOG2-1:0] upd_ply,
  input  logic [BOARD_WIDTH-1:0]    upd_board,
  input  logic                      clr_valid,
  output logic                      clr_ready,
  input  logic                      eval_req,
  input  logic [MAX_DEPTH_LOG2-1:0] eval_ply,
  output logic                      eval_grant,
  output logic [MAX_DEPTH_LOG2-1:0] killer_ply,
  output logic [BOARD_WIDTH-1:0]    killer_board,
  output logic                      killer_update,
  output logic                      killer_clear,
  output logic                      busy
);

  localparam int REQ_W = MAX_DEPTH_LOG2 + BOARD_WIDTH;
  localparam int CNT_W = cnt_width(SETUP_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR_PULSE, S_GAP, S_UPD_SETUP, S_UPD_PULSE, S_EVAL
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      last_eval_q, last_eval_d;
  logic [MAX_DEPTH_LOG2-1:0] ply_q, ply_d;
  logic [BOARD_WIDTH-1:0]    board_q, board_d;
  logic                      update_q, update_d;
  logic                      clear_q, clear_d;
  logic                      grant_q, grant_d;
  logic                      clr_ready_q, clr_ready_d;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [REQ_W-1:0] fifo_rd_data;

  assign fifo_push = upd_valid && !fifo_full;

  killer_req_fifo #(
    .WIDTH      (REQ_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wr_data ({upd_ply, upd_board}),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state and registered-output values; the setup cycle count starts
  // once the popped entry is visible on the FIFO read port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_eval_d = last_eval_q;
    ply_d       = ply_q;
    board_d     = board_q;
    update_d    = 1'b0;
    clear_d     = 1'b0;
    clr_ready_d = 1'b0;
    grant_d     = grant_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_valid) begin
          state_d     = S_CLR_PULSE;
          clear_d     = 1'b1;
          clr_ready_d = 1'b1;
          fifo_flush  = 1'b1;
        end else if (!fifo_empty && (!eval_req || last_eval_q)) begin
          state_d     = S_UPD_SETUP;
          fifo_pop    = 1'b1;
          last_eval_d = 1'b0;
          cnt_d       = SETUP_LOAD;
        end else if (eval_req) begin
          state_d = S_EVAL;
          grant_d = 1'b1;
          ply_d   = eval_ply;
        end
      end
      S_CLR_PULSE: begin
        state_d = S_GAP;
        cnt_d   = GAP_LOAD;
      end
      S_UPD_SETUP: begin
        if (cnt_q == SETUP_LOAD) {ply_d, board_d} = fifo_rd_data;
        if (cnt_q == '0) begin
          state_d  = S_UPD_PULSE;
          update_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_UPD_PULSE: begin
        state_d = S_GAP;
        cnt_d   = GAP_LOAD;
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_EVAL: begin
        if (eval_req) begin
          ply_d = eval_ply;
        end else begin
          state_d     = S_IDLE;
          grant_d     = 1'b0;
          last_eval_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any pulse immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_eval_q <= 1'b0;
      ply_q       <= '0;
      board_q     <= '0;
      update_q    <= 1'b0;
      clear_q     <= 1'b0;
      grant_q     <= 1'b0;
      clr_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_eval_q <= last_eval_d;
      ply_q       <= ply_d;
      board_q     <= board_d;
      update_q    <= update_d;
      clear_q     <= clear_d;
      grant_q     <= grant_d;
      clr_ready_q <= clr_ready_d;
    end
  end

  assign upd_ready     = !fifo_full;
  assign clr_ready     = clr_ready_q;
  assign eval_grant    = grant_q;
  assign killer_ply    = ply_q;
  assign killer_board  = board_q;
  assign killer_update = update_q;
  assign killer_clear  = clear_q;
  assign busy          = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_killer_sequencer.sv
// Self-checking bench for killer_sequencer: directed scenarios plus a randomized
// run scored against an in-order queue of accepted updates.
module tb_killer_sequencer;
  import killer_sequencer_pkg::*;

  localparam int PW     = 6;
  localparam int SETUP  = 3;
  localparam int GAP    = 1;
  localparam int T_PLY  = 2;
  localparam int T_UPD  = 2 + SETUP;
  localparam int T_IDLE = T_UPD + 1 + GAP;
  localparam int T_CLR  = T_IDLE + 1;

  typedef struct packed {
    logic [PW-1:0]          ply;
    logic [BOARD_WIDTH-1:0] board;
  } upd_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   upd_valid = 1'b0;
  logic                   upd_ready;
  logic [PW-1:0]          upd_ply = '0;
  logic [BOARD_WIDTH-1:0] upd_board = '0;
  logic                   clr_valid = 1'b0;
  logic                   clr_ready;
  logic                   eval_req = 1'b0;
  logic [PW-1:0]          eval_ply = '0;
  logic                   eval_grant;
  logic [PW-1:0]          killer_ply;
  logic [BOARD_WIDTH-1:0] killer_board;
  logic                   killer_update;
  logic                   killer_clear;
  logic                   busy;

  int n_checks = 0;
  int n_pass   = 0;

  upd_t                   model_q[$];
  int                     seen_cyc[$];
  logic [PW-1:0]          seen_ply[$];
  logic [BOARD_WIDTH-1:0] seen_board[$];
  int                     clr_seen;
  int                     spacing_bad;

  always #5 clk = ~clk;

  killer_sequencer #(
    .MAX_DEPTH_LOG2  (PW),
    .SETUP_CYCLES    (SETUP),
    .GAP_CYCLES      (GAP),
    .FIFO_DEPTH_LOG2 (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_ply       (upd_ply),
    .upd_board     (upd_board),
    .clr_valid     (clr_valid),
    .clr_ready     (clr_ready),
    .eval_req      (eval_req),
    .eval_ply      (eval_ply),
    .eval_grant    (eval_grant),
    .killer_ply    (killer_ply),
    .killer_board  (killer_board),
    .killer_update (killer_update),
    .killer_clear  (killer_clear),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BOARD_WIDTH-1:0] rand_board();
    return BOARD_WIDTH'({$urandom(), $urandom()});
  endfunction

  // Records every pulse over a fixed window, plus spacing violations.
  task automatic collect(input int cycles);
    logic prev;
    seen_cyc.delete();
    seen_ply.delete();
    seen_board.delete();
    clr_seen    = 0;
    spacing_bad = 0;
    prev        = 1'b0;
    for (int c = 1; c <= cycles; c++) begin
      tick();
      if (killer_update) begin
        seen_cyc.push_back(c);
        seen_ply.push_back(killer_ply);
        seen_board.push_back(killer_board);
      end
      if (killer_clear) clr_seen++;
      if ((killer_update && killer_clear) || (prev && (killer_update || killer_clear)))
        spacing_bad++;
      prev = killer_update || killer_clear;
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({killer_update, killer_clear, eval_grant, clr_ready, upd_ready, busy} !== 6'b000010)
      $display("FAIL reset_flags: got %b want 000010",
               {killer_update, killer_clear, eval_grant, clr_ready, upd_ready, busy});
    else n_pass++;
    n_checks++;
    if ({killer_ply, killer_board} !== '0)
      $display("FAIL reset_bus: got ply %0d board %h want 0", killer_ply, killer_board);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_checks++;
    if ({upd_ready, busy, eval_grant} !== 3'b100)
      $display("FAIL reset_release: got %b want 100", {upd_ready, busy, eval_grant});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [BOARD_WIDTH-1:0] b;
    b = rand_board();
    upd_valid = 1'b1; upd_ply = PW'(5); upd_board = b;
    tick();
    upd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= T_PLY && k <= T_IDLE) begin
        n_checks++;
        if ({killer_ply, killer_board} !== {PW'(5), b})
          $display("FAIL single_bus k=%0d: got ply %0d board %h want 5 %h", k, killer_ply, killer_board, b);
        else n_pass++;
      end
      n_checks++;
      if (killer_update !== (k == T_UPD))
        $display("FAIL single_pulse k=%0d: got %b want %b", k, killer_update, (k == T_UPD));
      else n_pass++;
      if (k == T_IDLE - 1 || k == T_IDLE) begin
        n_checks++;
        if (busy !== (k == T_IDLE - 1))
          $display("FAIL single_busy k=%0d: got %b want %b", k, busy, (k == T_IDLE - 1));
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [BOARD_WIDTH-1:0] bd[3];
    logic r, accepted;
    for (int i = 0; i < 3; i++) bd[i] = rand_board();
    eval_req = 1'b1; eval_ply = '0;
    tick();
    for (int i = 0; i < 2; i++) begin
      upd_valid = 1'b1; upd_ply = PW'(i + 1); upd_board = bd[i];
      tick();
    end
    n_checks++;
    if (upd_ready !== 1'b0) $display("FAIL b2b_full: upd_ready %b want 0", upd_ready);
    else n_pass++;
    upd_ply = PW'(3); upd_board = bd[2];
    eval_req = 1'b0;
    accepted = 1'b0;
    for (int c = 0; c < 12 && !accepted; c++) begin
      r = upd_ready;
      tick();
      if (r) accepted = 1'b1;
    end
    upd_valid = 1'b0;
    n_checks++;
    if (!accepted) $display("FAIL b2b_third_accept: not accepted within 12 cycles");
    else n_pass++;
    collect(60);
    n_checks++;
    if (seen_ply.size() != 3) $display("FAIL b2b_count: got %0d pulses want 3", seen_ply.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= seen_ply.size())
        $display("FAIL b2b_order[%0d]: pulse missing, want ply %0d", i, i + 1);
      else if ({seen_ply[i], seen_board[i]} !== {PW'(i + 1), bd[i]})
        $display("FAIL b2b_order[%0d]: got ply %0d board %h want %0d %h", i, seen_ply[i], seen_board[i], i + 1, bd[i]);
      else n_pass++;
    end
    n_checks++;
    if (spacing_bad != 0) $display("FAIL b2b_spacing: %0d violations want 0", spacing_bad);
    else n_pass++;
  endtask

  task automatic test_eval();
    logic [PW-1:0] p;
    logic [BOARD_WIDTH-1:0] b;
    logic [PW-1:0] got_ply;
    logic [BOARD_WIDTH-1:0] got_board;
    logic seen, early, granted;
    b = rand_board();
    eval_req = 1'b1; eval_ply = PW'(7);
    tick();
    n_checks++;
    if ({eval_grant, killer_ply} !== {1'b1, PW'(7)})
      $display("FAIL eval_grant_start: got grant %b ply %0d want 1 7", eval_grant, killer_ply);
    else n_pass++;
    upd_valid = 1'b1; upd_ply = PW'(2); upd_board = b;
    for (int i = 0; i < 10; i++) begin
      p = (i == 0) ? PW'(7) : PW'($urandom());
      eval_ply = p;
      tick();
      upd_valid = 1'b0;
      n_checks++;
      if ({eval_grant, killer_update, killer_ply} !== {1'b1, 1'b0, p})
        $display("FAIL eval_hold[%0d]: got grant %b upd %b ply %0d want 1 0 %0d", i, eval_grant, killer_update, killer_ply, p);
      else n_pass++;
    end
    eval_req = 1'b0;
    tick();
    n_checks++;
    if (eval_grant !== 1'b0) $display("FAIL eval_release: grant %b want 0", eval_grant);
    else n_pass++;
    eval_req = 1'b1; eval_ply = PW'(9);
    seen = 1'b0; early = 1'b0; granted = 1'b0;
    got_ply = '0; got_board = '0;
    for (int c = 0; c < 40 && !granted; c++) begin
      tick();
      if (killer_update) begin seen = 1'b1; got_ply = killer_ply; got_board = killer_board; end
      if (eval_grant) begin granted = 1'b1; if (!seen) early = 1'b1; end
    end
    n_checks++;
    if (!seen || {got_ply, got_board} !== {PW'(2), b})
      $display("FAIL eval_queued_update: seen %b ply %0d board %h want 1 2 %h", seen, got_ply, got_board, b);
    else n_pass++;
    n_checks++;
    if (early || !granted)
      $display("FAIL eval_regrant: early %b granted %b want 0 1", early, granted);
    else n_pass++;
    eval_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_clear_queued();
    int rdy_cnt, clr_cnt, upd_cnt, apart;
    eval_req = 1'b1; eval_ply = '0;
    tick();
    for (int i = 0; i < 2; i++) begin
      upd_valid = 1'b1; upd_ply = PW'($urandom()); upd_board = rand_board();
      tick();
    end
    upd_valid = 1'b0;
    clr_valid = 1'b1; eval_req = 1'b0;
    rdy_cnt = 0; clr_cnt = 0; upd_cnt = 0; apart = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (clr_ready) begin rdy_cnt++; clr_valid = 1'b0; end
      if (killer_clear) clr_cnt++;
      if (killer_update) upd_cnt++;
      if (clr_ready !== killer_clear) apart++;
    end
    clr_valid = 1'b0;
    n_checks++;
    if (rdy_cnt != 1 || clr_cnt != 1 || apart != 0)
      $display("FAIL clr_pulse: clr_ready %0d killer_clear %0d apart %0d want 1 1 0", rdy_cnt, clr_cnt, apart);
    else n_pass++;
    n_checks++;
    if (upd_cnt != 0) $display("FAIL clr_flush: got %0d updates want 0", upd_cnt);
    else n_pass++;
    n_checks++;
    if ({upd_ready, busy} !== 2'b10) $display("FAIL clr_after: got %b want 10", {upd_ready, busy});
    else n_pass++;
  endtask

  task automatic test_clear_in_setup();
    int upd_at, clr_at;
    upd_valid = 1'b1; upd_ply = PW'($urandom()); upd_board = rand_board();
    tick();
    upd_valid = 1'b0;
    upd_at = -1; clr_at = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (killer_update && upd_at < 0) upd_at = k;
      if (killer_clear && clr_at < 0) clr_at = k;
      if (clr_ready) clr_valid = 1'b0;
      else if (k == T_PLY) clr_valid = 1'b1;
    end
    clr_valid = 1'b0;
    n_checks++;
    if (upd_at != T_UPD) $display("FAIL setup_clr_update: at %0d want %0d", upd_at, T_UPD);
    else n_pass++;
    n_checks++;
    if (clr_at != T_CLR) $display("FAIL setup_clr_clear: at %0d want %0d", clr_at, T_CLR);
    else n_pass++;
  endtask

  task automatic test_random();
    upd_t e;
    logic r, v, prev;
    model_q.delete();
    prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      v = (c < 300) && ($urandom_range(0, 2) == 0);
      upd_valid = v; upd_ply = PW'($urandom()); upd_board = rand_board();
      if (c >= 300) eval_req = 1'b0;
      else if (!eval_req && $urandom_range(0, 5) == 0) eval_req = 1'b1;
      else if (eval_grant && $urandom_range(0, 3) == 0) eval_req = 1'b0;
      eval_ply = PW'($urandom());
      r = upd_ready;
      tick();
      if (v && r) begin
        e.ply = upd_ply; e.board = upd_board;
        model_q.push_back(e);
      end
      if (killer_update) begin
        n_checks++;
        if (model_q.size() == 0)
          $display("FAIL rand_unexpected: ply %0d with nothing queued", killer_ply);
        else begin
          e = model_q.pop_front();
          if ({killer_ply, killer_board} !== {e.ply, e.board})
            $display("FAIL rand_order c=%0d: got %0d %h want %0d %h", c, killer_ply, killer_board, e.ply, e.board);
          else n_pass++;
        end
      end
      n_checks++;
      if ((killer_update && (killer_clear || eval_grant)) || (prev && killer_update))
        $display("FAIL rand_spacing c=%0d: upd %b clr %b grant %b prev %b", c, killer_update, killer_clear, eval_grant, prev);
      else n_pass++;
      prev = killer_update || killer_clear;
    end
    upd_valid = 1'b0;
    n_checks++;
    if (model_q.size() != 0) $display("FAIL rand_drain: %0d updates never pulsed", model_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    logic found;
    upd_valid = 1'b1; upd_ply = PW'($urandom()); upd_board = rand_board();
    tick();
    upd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 15 && !found; c++) begin
      tick();
      if (killer_update) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL rst_pulse_wait: no killer_update within 15 cycles");
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (killer_update !== 1'b0) $display("FAIL rst_async_drop: killer_update %b want 0", killer_update);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_checks++;
    if ({upd_ready, busy, killer_update, killer_ply} !== {3'b100, PW'(0)})
      $display("FAIL rst_after: ready %b busy %b upd %b ply %0d want 1 0 0 0", upd_ready, busy, killer_update, killer_ply);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_eval();
    test_clear_queued();
    test_clear_in_setup();
    test_random();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
